inst_fetch_align: RTL and testbench

INST_FETCH_ALIGN -- requirements
Module: inst_fetch_align

---
 rtl/rv_fetch_pkg.sv | 22 ++
 rtl/parcel_buf.sv | 51 +++++
 rtl/inst_fetch_align.sv | 121 ++++++++++++
 tb/tb_inst_fetch_align.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch/align slice: FSM encoding,
// parcel geometry and the compressed-instruction test.
package rv_fetch_pkg;

  localparam int PARCEL_W  = 16;
  localparam int BUF_DEPTH = 4;
  localparam int ILEN      = 32;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W     = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Any parcel whose two low bits are not 11 starts a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] lsbs);
    return lsbs != 2'b11;
  endfunction

endpackage

// File: rtl/parcel_buf.sv
// Four-entry halfword FIFO: up to two parcels popped from the head and up to
// two pushed at the tail each cycle; clear wins over both.
module parcel_buf
  import rv_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [1:0]            pop_n,
  input  logic [1:0]            push_n,
  input  logic [2*PARCEL_W-1:0] push_data,
  output logic [PARCEL_W-1:0]   p0,
  output logic [PARCEL_W-1:0]   p1,
  output logic [CNT_W-1:0]      count
);

  logic [PARCEL_W-1:0] entry      [BUF_DEPTH];
  logic [PARCEL_W-1:0] entry_next [BUF_DEPTH];
  logic [CNT_W-1:0]    kept;
  logic [CNT_W-1:0]    count_next;

  assign kept       = count - CNT_W'(pop_n);
  assign count_next = clear ? '0 : kept + CNT_W'(push_n);

  assign p0 = entry[0];
  assign p1 = entry[1];

  // Surviving parcels shift down by the pop amount; new parcels land right after them.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      entry_next[i] = entry[i];
      if (CNT_W'(i) < kept)
        entry_next[i] = entry[IDX_W'(CNT_W'(i) + CNT_W'(pop_n))];
      else if (CNT_W'(i) - kept < CNT_W'(push_n))
        entry_next[i] = (CNT_W'(i) == kept) ? push_data[PARCEL_W-1:0]
                                            : push_data[2*PARCEL_W-1:PARCEL_W];
    end
  end

  always_ff @(posedge clk) begin
    entry <= entry_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/inst_fetch_align.sv
// Fetches aligned 32-bit words, splits them into parcels and presents whole
// 16/32-bit instructions with their PC; handles redirects and stale responses.
module inst_fetch_align
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic            out_is_c,
  output logic [31:0]     out_pc,
  input  logic            out_ready,
  input  logic            redir_valid,
  input  logic [31:0]     redir_pc
);

  fetch_state_e        state;
  logic [31:0]         fetch_addr;
  logic                skip;
  logic [PARCEL_W-1:0] p0;
  logic [PARCEL_W-1:0] p1;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_after_pop;
  logic                head_is_c;
  logic                fire;
  logic                fill;
  logic [1:0]          pop_n;
  logic [1:0]          push_n;
  logic [ILEN-1:0]     push_data;

  assign head_is_c = is_compressed(p0[1:0]);
  assign out_valid = (count >= CNT_W'(1) && head_is_c) || (count >= CNT_W'(2));
  assign out_is_c  = head_is_c;
  assign out_instr = head_is_c ? {16'h0000, p0} : {p1, p0};

  assign fire   = out_valid && out_ready;
  assign pop_n  = fire ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;

  // A response only fills the buffer if it belongs to the current stream.
  assign fill      = (state == WAIT) && mem_ack && !redir_valid;
  assign push_n    = fill ? (skip ? 2'd1 : 2'd2) : 2'd0;
  assign push_data = skip ? {16'h0000, mem_rdata[31:16]} : mem_rdata;

  assign count_after_pop = count - CNT_W'(pop_n);

  parcel_buf u_parcel_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redir_valid),
    .pop_n     (pop_n),
    .push_n    (push_n),
    .push_data (push_data),
    .p0        (p0),
    .p1        (p1),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_pc <= RESET_PC & ~32'd1;
    else if (redir_valid)
      out_pc <= redir_pc & ~32'd1;
    else if (fire)
      out_pc <= out_pc + (head_is_c ? 32'd2 : 32'd4);
  end

  // Request FSM: one outstanding fetch at most; a redirect while waiting
  // turns the pending response into one that is dropped on arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      mem_req    <= 1'b0;
      mem_addr   <= {RESET_PC[31:2], 2'b00};
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      skip       <= RESET_PC[1];
    end else begin
      if (redir_valid) begin
        fetch_addr <= {redir_pc[31:2], 2'b00};
        skip       <= redir_pc[1];
      end
      unique case (state)
        RUN: begin
          if (!redir_valid && count_after_pop <= CNT_W'(2)) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RUN;
            if (!redir_valid) begin
              fetch_addr <= fetch_addr + 32'd4;
              skip       <= 1'b0;
            end
          end else if (redir_valid) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RUN;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_align.sv
// Directed bench: a responder models memory, a monitor scores every accepted
// instruction against a queue of hand-computed expectations.
module tb_inst_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_is_c;
  logic [31:0] out_pc;
  logic        out_ready = 1'b1;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic        is_c;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mem [128];
  logic [31:0] mem_limit = '0;
  int          stray_cnt = 0;
  int          stray_done = 0;
  int          total = 0;
  int          bad = 0;
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_is_c    (out_is_c),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic is_c, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.is_c  = is_c;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic responder();
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        mem_ack    = 1'b1;
        mem_rdata  = 32'h1234_5678;
        stray_done = stray_cnt;
      end else if (mem_req && !mem_ack && mem_addr < mem_limit) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[8:2]];
      end else begin
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_instr: got instr=%h pc=%h, required none", out_instr, out_pc);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_is_c !== e.is_c || out_pc !== e.pc) begin
            bad++;
            $display("FAIL instr: got instr=%h is_c=%b pc=%h required instr=%h is_c=%b pc=%h",
                     out_instr, out_is_c, out_pc, e.instr, e.is_c, e.pc);
          end
        end
      end
      if (mem_req && !req_prev) begin
        req_log.push_back(mem_addr);
        check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      end
      req_prev = mem_req;
    end
  endtask

  task automatic do_reset(input logic [31:0] limit, input logic ready);
    @(posedge clk); #1;
    rst_n       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = ready;
    mem_limit   = '0;
    @(posedge clk); #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    req_log.delete();
    rst_n     = 1'b1;
    mem_limit = limit;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    fork
      responder();
      monitor();
    join_none

    // Single word with two compressed parcels; first request right after reset.
    mem[0] = 32'h0001_4501;
    expect_instr(32'h0000_4501, 1'b1, 32'h0);
    expect_instr(32'h0000_0001, 1'b1, 32'h2);
    do_reset(32'd4, 1'b1);
    @(posedge clk); #1;
    check("t1_first_req", {31'd0, mem_req}, 32'd1);
    check("t1_first_addr", mem_addr, 32'h0);
    check("t1_no_valid", {31'd0, out_valid}, 32'd0);
    drain("t1");

    // 32-bit instruction followed by compressed ones.
    mem[0] = 32'h0051_0113;
    mem[1] = 32'h0000_4505;
    expect_instr(32'h0051_0113, 1'b0, 32'h0);
    expect_instr(32'h0000_4505, 1'b1, 32'h4);
    expect_instr(32'h0000_0000, 1'b1, 32'h6);
    do_reset(32'd8, 1'b1);
    drain("t2");

    // 32-bit instruction straddling two words.
    mem[0] = 32'h0093_8082;
    mem[1] = 32'h0000_0010;
    expect_instr(32'h0000_8082, 1'b1, 32'h0);
    expect_instr(32'h0010_0093, 1'b0, 32'h2);
    expect_instr(32'h0000_0000, 1'b1, 32'h6);
    do_reset(32'd8, 1'b1);
    drain("t3");

    // Redirect to a halfword-offset target while a fetch is outstanding.
    mem[0]  = 32'hDEAD_BEEF;
    mem[64] = 32'h4509_1234;
    mem[65] = 32'h0000_0000;
    do_reset(32'd0, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("t038_waiting", {31'd0, mem_req}, 32'd1);
    expect_instr(32'h0000_4509, 1'b1, 32'h102);
    expect_instr(32'h0000_0000, 1'b1, 32'h104);
    expect_instr(32'h0000_0000, 1'b1, 32'h106);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0102;
    @(posedge clk); #1;
    redir_valid = 1'b0;
    check("t038_valid_low", {31'd0, out_valid}, 32'd0);
    check("t038_req_held", {31'd0, mem_req}, 32'd1);
    check("t038_addr_held", mem_addr, 32'h0);
    check("t038_pc", out_pc, 32'h102);
    mem_limit = 32'h108;
    drain("t038");
    check("t038_nreq", req_log.size(), 32'd4);
    if (req_log.size() >= 2) check("t038_refetch", req_log[1], 32'h100);

    // Decoder stalled: buffer fills to four parcels and fetching stops.
    mem[0] = 32'h4585_4501;
    mem[1] = 32'h0041_0113;
    mem[2] = 32'h8082_4505;
    expect_instr(32'h0000_4501, 1'b1, 32'h0);
    expect_instr(32'h0000_4585, 1'b1, 32'h2);
    expect_instr(32'h0041_0113, 1'b0, 32'h4);
    expect_instr(32'h0000_4505, 1'b1, 32'h8);
    expect_instr(32'h0000_8082, 1'b1, 32'hA);
    do_reset(32'd12, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("t039_req_low", {31'd0, mem_req}, 32'd0);
    check("t039_nreq", req_log.size(), 32'd2);
    check("t039_valid", {31'd0, out_valid}, 32'd1);
    check("t039_head", out_instr, 32'h0000_4501);
    out_ready = 1'b1;
    drain("t039");

    // Reset pulse during an outstanding fetch, then a stray response.
    do_reset(32'd0, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("t040_waiting", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t040_async_req", {31'd0, mem_req}, 32'd0);
    check("t040_async_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    mem[0] = 32'h0001_4501;
    expect_instr(32'h0000_4501, 1'b1, 32'h0);
    expect_instr(32'h0000_0001, 1'b1, 32'h2);
    rst_n     = 1'b1;
    stray_cnt = stray_cnt + 1;
    mem_limit = 32'd4;
    @(posedge clk); #1;
    check("t040_req", {31'd0, mem_req}, 32'd1);
    check("t040_addr", mem_addr, 32'h0);
    check("t040_no_valid", {31'd0, out_valid}, 32'd0);
    drain("t040");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
